polygon_edge_sequencer: RTL and testbench
=========================================

// Module: polygon_edge_sequencer
// PURPOSE
//  Parametrised successor to the fixed 3-vertex edge walker.
//  Snapshots a polygon of 3..MAX_VERTS vertices on start, then emits one edge per handshake.
//  Edges are emitted as endpoint pairs (v0,v1),(v1,v2)...(vN-1,v0) over a valid/ready interface.
//  Sits between the vertex source and the line rasteriser in the pixel pipeline.
// PARAMETERS
//  COORD_W    32  width of each x/y coordinate (unsigned)
//  MAX_VERTS  8   maximum vertex count, >=3
//  CNT_W      $clog2(MAX_VERTS+1)  width of num_verts / edge_index (localparam)
// PORTS
//  clk             in   1                  clock, rising edge
//  reset_n         in   1                  asynchronous reset, active-low
//  start           in   1                  1-cycle request; sampled only in IDLE
//  num_verts       in   CNT_W              vertex count, sampled with start
//  x_verts         in   MAX_VERTS*COORD_W  vertex i at bits [i*COORD_W +: COORD_W]
//  y_verts         in   MAX_VERTS*COORD_W  same packing as x_verts
//  x_coordinate_1  out  COORD_W            edge start x
//  y_coordinate_1  out  COORD_W            edge start y
//  x_coordinate_2  out  COORD_W            edge end x
//  y_coordinate_2  out  COORD_W            edge end y
//  edge_index      out  CNT_W              index of current edge, 0..N-1
//  edge_valid      out  1                  edge outputs valid
//  edge_ready      in   1                  downstream accepts the edge
//  last_edge       out  1                  current edge is the closing edge (vN-1,v0)
//  busy            out  1                  high outside IDLE
//  done            out  1                  1-cycle pulse at end of polygon
//  err             out  1                  1-cycle pulse: start with num_verts<3 or >MAX_VERTS
// BEHAVIOUR
//  - Reset (reset_n low, async): state IDLE; every output 0; vertex snapshot cleared to 0.
//  - States: IDLE, EMIT, DONE.
//  - IDLE:
//     - start=1 with legal N: register all vertices and N, set edge_index=0, go to EMIT.
//     - Outputs present edge 0 with edge_valid=1 on the next cycle (latency 1 clk).
//  - Illegal N (<3 or >MAX_VERTS): err pulses 1 cycle, done not asserted, stay IDLE.
//  - Snapshot isolation: x_verts/y_verts/num_verts changes after the start cycle have no effect.
//  - EMIT, edge k:
//     - coord_1 = v[k]; coord_2 = v[(k+1) mod N].
//     - last_edge = (k==N-1).
//  - Handshake:
//     - Transfer occurs when edge_valid & edge_ready.
//     - While edge_valid=1 and edge_ready=0, all edge outputs hold stable.
//     - edge_valid never drops without a transfer.
//  - On transfer of edge k<N-1: present edge k+1 next cycle.
//     - Back-to-back transfers give 1 edge/clk.
//  - On transfer of the last edge: edge_valid=0 next cycle, go to DONE.
//  - DONE: done=1 for exactly one cycle, then IDLE. busy is 1 in EMIT and DONE.
//  - start outside IDLE is ignored (no queuing).
//  - Reset mid-operation aborts immediately:
//     - Outputs go to 0; no done/err.
//     - The first edge after release requires a fresh start.
//  - Wrap arithmetic: (k+1) mod N uses compare-to-(N-1), not power-of-2 masking.
//  - N=MAX_VERTS is legal.
//  - Coordinates are passed through unmodified; no arithmetic on coordinate values.
// CONFIGURATION
//  POLY_REPEAT_EN defined:
//   - Transfer of the last edge wraps to edge 0 instead of entering DONE.
//   - Edges loop indefinitely with the same snapshot, reproducing the legacy continuous walk.
//   - done pulses 1 cycle on each wrap; last_edge is unchanged.
//   - Exit only via reset_n.
//  POLY_REPEAT_EN undefined: one pass per start, as described in BEHAVIOUR.
// TESTING
//  1. Triangle, N=3, v=(10,20),(30,40),(50,60), edge_ready=1:
//     - Expect edges (10,20)-(30,40), (30,40)-(50,60), (50,60)-(10,20) on 3 consecutive clks.
//     - last_edge on the 3rd edge; done 1 clk later.
//  2. Backpressure, N=4, ready low for 5 clks on edge 1:
//     - Edge 1 outputs stable for all 5 clks.
//     - Exactly 4 transfers total, edge_index 0,1,2,3.
//  3. N=2 and N=MAX_VERTS+1 on start:
//     - err pulses 1 clk; busy stays 0; no edge_valid.
//     - Then N=MAX_VERTS gives MAX_VERTS edges; closing edge (v7,v0).
//  4. Snapshot isolation:
//     - Change all x_verts to 0xFFFF_FFFF the clk after start.
//     - Emitted edges still carry the original values.
//     - A second start while busy is ignored.
//  5. Reset mid-run:
//     - Assert reset_n=0 asynchronously during edge 2 of N=5.
//     - All outputs 0 before the next clk edge.
//     - After release: no activity until start.
//  6. POLY_REPEAT_EN build, N=3, ready=1:
//     - Edge sequence 0,1,2,0,1,2... for 12 clks.
//     - done pulses on each of 4 wraps.

Source files
------------

// File: rtl/polygon_edge_sequencer.sv
// polygon_edge_sequencer: snapshots a 3..MAX_VERTS vertex polygon on start and
// emits its edges (v0,v1),(v1,v2)..(vN-1,v0) one per valid/ready handshake.
// Optional build macro: POLY_REPEAT_EN -- loop over the same snapshot forever,
// pulsing done on each wrap; only reset_n leaves the loop.
module polygon_edge_sequencer #(
    parameter  int COORD_W   = 32,
    parameter  int MAX_VERTS = 8,
    localparam int CNT_W     = $clog2(MAX_VERTS + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [CNT_W-1:0]              num_verts,
    input  logic [MAX_VERTS*COORD_W-1:0]  x_verts,
    input  logic [MAX_VERTS*COORD_W-1:0]  y_verts,
    output logic [COORD_W-1:0]            x_coordinate_1,
    output logic [COORD_W-1:0]            y_coordinate_1,
    output logic [COORD_W-1:0]            x_coordinate_2,
    output logic [COORD_W-1:0]            y_coordinate_2,
    output logic [CNT_W-1:0]              edge_index,
    output logic                          edge_valid,
    input  logic                          edge_ready,
    output logic                          last_edge,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    // Vertex select width: indices never exceed MAX_VERTS-1.
    localparam int IDX_W = (MAX_VERTS > 1) ? $clog2(MAX_VERTS) : 1;
    localparam logic [CNT_W-1:0] MIN_N = CNT_W'(3);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_VERTS);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     n_q, n_d;
    logic [CNT_W-1:0]                     idx_q, idx_d;
    logic [MAX_VERTS-1:0][COORD_W-1:0]    xs_q, xs_d;
    logic [MAX_VERTS-1:0][COORD_W-1:0]    ys_q, ys_d;
    logic                                 err_q, err_d;
    logic                                 done_q, done_d;

    logic                                 emit;
    logic                                 is_last;
    logic                                 legal_n;
    logic [CNT_W-1:0]                     nxt_idx;
    logic [IDX_W-1:0]                     sel_a, sel_b;

    // Edge index arithmetic: wrap by compare against N-1 so any N works.
    always_comb begin
        emit    = (state_q == S_EMIT);
        is_last = (idx_q == n_q - ONE);
        nxt_idx = is_last ? '0 : idx_q + ONE;
        legal_n = (num_verts >= MIN_N) && (num_verts <= MAX_N);
        sel_a   = idx_q[IDX_W-1:0];
        sel_b   = nxt_idx[IDX_W-1:0];
    end

    // Next-state logic: snapshot on legal start, advance index on each transfer.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal_n) begin
                        n_d     = num_verts;
                        idx_d   = '0;
                        xs_d    = x_verts;
                        ys_d    = y_verts;
                        state_d = S_EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (edge_ready) begin
                    if (is_last) begin
                        done_d = 1'b1;
`ifdef POLY_REPEAT_EN
                        idx_d  = '0;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d = nxt_idx;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and snapshot registers; reset clears everything including vertices.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Outputs are forced to zero outside EMIT so idle/abort looks clean downstream.
    always_comb begin
        edge_valid     = emit;
        edge_index     = emit ? idx_q : '0;
        last_edge      = emit && is_last;
        x_coordinate_1 = emit ? xs_q[sel_a] : '0;
        y_coordinate_1 = emit ? ys_q[sel_a] : '0;
        x_coordinate_2 = emit ? xs_q[sel_b] : '0;
        y_coordinate_2 = emit ? ys_q[sel_b] : '0;
        busy           = (state_q != S_IDLE);
        done           = done_q;
        err            = err_q;
    end

endmodule

// File: tb/tb_polygon_edge_sequencer.sv
// Directed bench for polygon_edge_sequencer: table-driven edge sequences plus
// hand-written sequences for illegal N, snapshot isolation and mid-run reset.
module tb_polygon_edge_sequencer;

    localparam int COORD_W   = 32;
    localparam int MAX_VERTS = 8;
    localparam int CNT_W     = $clog2(MAX_VERTS + 1);

    logic                         clk = 1'b0;
    logic                         reset_n = 1'b0;
    logic                         start = 1'b0;
    logic [CNT_W-1:0]             num_verts = '0;
    logic [MAX_VERTS*COORD_W-1:0] x_verts = '0;
    logic [MAX_VERTS*COORD_W-1:0] y_verts = '0;
    logic [COORD_W-1:0]           x1, y1, x2, y2;
    logic [CNT_W-1:0]             edge_index;
    logic                         edge_valid, edge_ready = 1'b0, last_edge, busy, done, err;

    polygon_edge_sequencer #(.COORD_W(COORD_W), .MAX_VERTS(MAX_VERTS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_verts(num_verts),
        .x_verts(x_verts), .y_verts(y_verts),
        .x_coordinate_1(x1), .y_coordinate_1(y1),
        .x_coordinate_2(x2), .y_coordinate_2(y2),
        .edge_index(edge_index), .edge_valid(edge_valid), .edge_ready(edge_ready),
        .last_edge(last_edge), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int xfers = 0;

    always @(posedge clk) if (edge_valid && edge_ready) xfers <= xfers + 1;

    typedef struct {
        logic rdy;
        logic vld;
        int   idx;
        int   a;
        int   b;
        logic last;
        logic done;
        logic busy;
    } row_t;

    row_t tbl[$];

    function automatic logic [31:0] vx(int i); return 32'(10 + 20 * i); endfunction
    function automatic logic [31:0] vy(int i); return 32'(20 + 20 * i); endfunction

    function automatic row_t mk(logic r, logic v, int k, int n, logic d, logic b);
        row_t t;
        t.rdy = r; t.vld = v; t.idx = v ? k : 0;
        t.a = k; t.b = (k + 1) % n;
        t.last = v && (k == n - 1);
        t.done = d; t.busy = b;
        return t;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_verts();
        for (int i = 0; i < MAX_VERTS; i++) begin
            x_verts[i*COORD_W +: COORD_W] = vx(i);
            y_verts[i*COORD_W +: COORD_W] = vy(i);
        end
    endtask

    // Called at a negedge; returns at the negedge where edge 0 should show.
    task automatic start_poly(int n);
        load_verts();
        num_verts = CNT_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_table(string tag, int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            row_t r;
            r = tbl[i];
            edge_ready = r.rdy;
            chk($sformatf("%s[%0d].valid", tag, i - lo), 64'(edge_valid), 64'(r.vld));
            chk($sformatf("%s[%0d].idx", tag, i - lo), 64'(edge_index), 64'(r.idx));
            chk($sformatf("%s[%0d].x1", tag, i - lo), 64'(x1), r.vld ? 64'(vx(r.a)) : 64'd0);
            chk($sformatf("%s[%0d].y1", tag, i - lo), 64'(y1), r.vld ? 64'(vy(r.a)) : 64'd0);
            chk($sformatf("%s[%0d].x2", tag, i - lo), 64'(x2), r.vld ? 64'(vx(r.b)) : 64'd0);
            chk($sformatf("%s[%0d].y2", tag, i - lo), 64'(y2), r.vld ? 64'(vy(r.b)) : 64'd0);
            chk($sformatf("%s[%0d].last", tag, i - lo), 64'(last_edge), 64'(r.last));
            chk($sformatf("%s[%0d].done", tag, i - lo), 64'(done), 64'(r.done));
            chk($sformatf("%s[%0d].busy", tag, i - lo), 64'(busy), 64'(r.busy));
            chk($sformatf("%s[%0d].err", tag, i - lo), 64'(err), 64'd0);
            @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(string name);
        chk(name, {x1, y1, x2, y2, 28'(edge_index), edge_valid, last_edge, busy, done, err} == '0 ? 64'd1 : 64'd0, 64'd1);
    endtask

    int tri_lo, tri_hi, bp_lo, bp_hi, big_lo, big_hi, x0;

    initial begin
        // Triangle, ready always high.
        tri_lo = tbl.size();
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 1, k, 3, 0, 1));
        tbl.push_back(mk(1, 0, 0, 3, 1, 1));
        tbl.push_back(mk(1, 0, 0, 3, 0, 0));
        tri_hi = tbl.size() - 1;
        // N=4 with 5 clocks of backpressure on edge 1.
        bp_lo = tbl.size();
        tbl.push_back(mk(1, 1, 0, 4, 0, 1));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 1, 1, 4, 0, 1));
        tbl.push_back(mk(1, 1, 1, 4, 0, 1));
        tbl.push_back(mk(1, 1, 2, 4, 0, 1));
        tbl.push_back(mk(1, 1, 3, 4, 0, 1));
        tbl.push_back(mk(1, 0, 0, 4, 1, 1));
        tbl.push_back(mk(1, 0, 0, 4, 0, 0));
        bp_hi = tbl.size() - 1;
        // N=MAX_VERTS, closing edge (v7,v0).
        big_lo = tbl.size();
        for (int k = 0; k < MAX_VERTS; k++) tbl.push_back(mk(1, 1, k, MAX_VERTS, 0, 1));
        tbl.push_back(mk(1, 0, 0, MAX_VERTS, 1, 1));
        tbl.push_back(mk(1, 0, 0, MAX_VERTS, 0, 0));
        big_hi = tbl.size() - 1;

        // Reset state.
        repeat (2) @(negedge clk);
        chk_all_zero("reset_outputs");
        reset_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle_after_reset");

        // 1: triangle.
        edge_ready = 1'b1;
        start_poly(3);
        run_table("tri", tri_lo, tri_hi);

        // 2: backpressure, exactly 4 transfers.
        x0 = xfers;
        start_poly(4);
        run_table("bp", bp_lo, bp_hi);
        chk("bp.transfers", 64'(xfers - x0), 64'd4);

        // 3: illegal N values.
        foreach (tbl[i]) if (i < 0) $display("unreachable");
        for (int t = 0; t < 2; t++) begin
            load_verts();
            num_verts = (t == 0) ? CNT_W'(2) : CNT_W'(MAX_VERTS + 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("illegal%0d.err", t), 64'(err), 64'd1);
            chk($sformatf("illegal%0d.busy", t), 64'(busy), 64'd0);
            chk($sformatf("illegal%0d.valid", t), 64'(edge_valid), 64'd0);
            chk($sformatf("illegal%0d.done", t), 64'(done), 64'd0);
            @(negedge clk);
            chk($sformatf("illegal%0d.err_pulse", t), 64'(err), 64'd0);
            chk($sformatf("illegal%0d.busy2", t), 64'(busy), 64'd0);
        end
        start_poly(MAX_VERTS);
        run_table("max", big_lo, big_hi);

        // 4: snapshot isolation and ignored second start.
        x0 = xfers;
        start_poly(3);
        x_verts = '1;
        num_verts = CNT_W'(5);
        start = 1'b1;
        run_table("snap", tri_lo, tri_lo + 1);
        start = 1'b0;
        run_table("snap", tri_lo + 2, tri_hi);
        chk("snap.transfers", 64'(xfers - x0), 64'd3);

        // 5: asynchronous reset during edge 2 of N=5.
        tbl.push_back(mk(1, 1, 2, 5, 0, 1));
        start_poly(5);
        edge_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst.edge2_idx", 64'(edge_index), 64'd2);
        chk("rst.edge2_x1", 64'(x1), 64'(vx(2)));
        #2 reset_n = 1'b0;
        #1 chk_all_zero("rst.async_clear");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_all_zero($sformatf("rst.quiet%0d", c));
        end
        start_poly(3);
        chk("rst.restart_valid", 64'(edge_valid), 64'd1);
        chk("rst.restart_idx", 64'(edge_index), 64'd0);
        chk("rst.restart_x2", 64'(x2), 64'(vx(1)));

`ifdef POLY_REPEAT_EN
        // 6: continuous loop over the triangle; done on each wrap.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        edge_ready = 1'b1;
        start_poly(3);
        for (int k = 0; k <= 12; k++) begin
            chk($sformatf("rep[%0d].idx", k), 64'(edge_index), 64'(k % 3));
            chk($sformatf("rep[%0d].valid", k), 64'(edge_valid), 64'd1);
            chk($sformatf("rep[%0d].last", k), 64'(last_edge), 64'((k % 3) == 2));
            chk($sformatf("rep[%0d].done", k), 64'(done), 64'((k % 3) == 0 && k > 0));
            chk($sformatf("rep[%0d].x1", k), 64'(x1), 64'(vx(k % 3)));
            @(negedge clk);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
